dmem_lsu_ctrl: RTL

Load/store sequencer placed between the core's memory stage and the byte-addressed, word-wide data memory. The memory has a 1-cycle registered read and writes a full 32-bit word on the falling edge whenever its write enable is high.
The block turns RISC-V-style LB/LH/LW/LBU/LHU/SB/SH/SW requests into memory transactions:
- Sub-word stores use read-modify-write on the aligned word.
- Misaligned, out-of-range and illegal accesses are rejected.
- Results go back through a valid/ready response handshake.

---
 rtl/dmem_lsu_pkg.sv | 37 +++
 rtl/dmem_lsu_lane.sv | 40 ++++
 rtl/dmem_lsu_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the data-memory load/store sequencer.
// Holds the funct3 encodings, the FSM state type and the access legality check.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // The address is passed zero-extended to 64 bits so that one function
  // serves any ADDR_W; last_word is the highest legal aligned word address.
  function automatic logic legal_access(input logic        we,
                                        input logic [2:0]  funct3,
                                        input logic [63:0] addr,
                                        input logic [63:0] last_word);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr[0];
      F3_W:    ok = (addr[1:0] == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~addr[0];
      default: ok = 1'b0;
    endcase
    if ((addr & ~64'd3) > last_word) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lsu_lane.sv
// Byte/halfword lane logic: load extraction with sign/zero extension and
// store merging of a sub-word into the previously read memory word.
module dmem_lsu_lane
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_data = {24'd0, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_HU:   load_data = {16'd0, half_v};
      default: load_data = word;
    endcase

    merge_word = word;
    case (funct3)
      F3_B: merge_word[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (lane[1]) merge_word[31:16] = wdata[15:0];
        else         merge_word[15:0]  = wdata[15:0];
      end
      default: merge_word = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the core memory stage and a word-wide data
// memory with 1-cycle registered read; sub-word stores use read-modify-write.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a request; legality decided on acceptance
// ST_ISSUE | word address on mem_addr; SW writes here, others start read
// ST_DATA  | mem_rdata valid; load extracted or sub-word merged and written
// ST_RESP  | response presented until rsp_ready
module dmem_lsu_ctrl
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wr_en,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam logic [63:0] LAST_WORD = 64'(DEPTH_BYTES - 4);

  state_t            state, state_nxt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              req_legal;
  logic [31:0]       load_data;
  logic [31:0]       merge_word;

  assign req_legal = legal_access(req_we, req_funct3, 64'(req_addr), LAST_WORD);

  // Address comes only from the registered request, so it is stable from
  // ISSUE through DATA and returns to 0 on reset.
  assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

  dmem_lsu_lane u_lane (
    .word       (mem_rdata),
    .wdata      (wdata_q),
    .lane       (addr_q[1:0]),
    .funct3     (f3_q),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = 32'd0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = req_legal ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE: begin
        if (we_q && f3_q == F3_W) begin
          mem_wr_en = 1'b1;
          mem_wdata = wdata_q;
          state_nxt = ST_RESP;
        end else begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (we_q) begin
          mem_wr_en = 1'b1;
          mem_wdata = merge_word;
        end
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        we_q      <= req_we;
        f3_q      <= req_funct3;
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        rsp_rdata <= 32'd0;
        rsp_err   <= ~req_legal;
      end
      if (state == ST_DATA && !we_q) rsp_rdata <= load_data;
    end
  end

endmodule
